// File: rtl/edge_detect_pkg.sv
// Shared constants for the multi-channel hit edge detector: channel modes,
// event polarity encoding and the event arbiter states.
package edge_detect_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam logic EV_RISE = 1'b1;
  localparam logic EV_FALL = 1'b0;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_PRESENT = 1'b1
  } arb_state_e;

  function automatic logic mode_accepts(input logic [1:0] mode, input logic ev_type);
    if (mode == MODE_OFF) return 1'b0;
    if (ev_type == EV_RISE) return (mode == MODE_RISE) || (mode == MODE_BOTH);
    return (mode == MODE_FALL) || (mode == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One hit channel: synchroniser, edge detect, mode qualification, hold-off and
// a single-entry pending slot. Raw pulses and pending appear SYNC_STAGES+1 cycles after sampling.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 4
`ifdef EDGE_DETECT_TIMESTAMP_EN
  , parameter int TS_W      = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hit,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 ack,
  input  logic                 clr_overflow,
`ifdef EDGE_DETECT_TIMESTAMP_EN
  input  logic [TS_W-1:0]      ts_now,
  output logic [TS_W-1:0]      ts,
`endif
  output logic                 rise,
  output logic                 fall,
  output logic                 pending,
  output logic                 ev_type,
  output logic                 overflow
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_e_q, rise_e_d, fall_e_q, fall_e_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic [HOLDOFF_W-1:0]   hold_q, hold_d;
  logic                   pend_q, pend_d, type_q, type_d, ovf_q, ovf_d;
  logic                   synced, new_type, qualified, accept;
`ifdef EDGE_DETECT_TIMESTAMP_EN
  logic [TS_W-1:0]        ts_q, ts_d;
`endif

  generate
    if (SYNC_STAGES == 1) begin : g_sync1
      assign sync_d = hit;
    end else begin : g_syncn
      assign sync_d = {sync_q[SYNC_STAGES-2:0], hit};
    end
  endgenerate

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    hist_d    = synced;
    rise_e_d  = synced & ~hist_q;
    fall_e_d  = ~synced & hist_q;
    rise_d    = rise_e_q & enable;
    fall_d    = fall_e_q & enable;
    new_type  = rise_e_q ? EV_RISE : EV_FALL;
    qualified = enable & (rise_e_q | fall_e_q) & mode_accepts(mode, new_type);
    accept    = qualified & (hold_q == '0);

    hold_d = hold_q;
    if (accept) hold_d = holdoff;
    else if (hold_q != '0) hold_d = hold_q - HOLDOFF_W'(1);

    pend_d = pend_q;
    type_d = type_q;
    ovf_d  = ovf_q;
`ifdef EDGE_DETECT_TIMESTAMP_EN
    ts_d   = ts_q;
`endif
    if (ack) pend_d = 1'b0;
    if (clr_overflow) ovf_d = 1'b0;
    // A slot being drained this cycle can take the new event without loss.
    if (accept) begin
      if (pend_q && !ack) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        type_d = new_type;
`ifdef EDGE_DETECT_TIMESTAMP_EN
        ts_d   = ts_now;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      rise_e_q <= 1'b0;
      fall_e_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      hold_q   <= '0;
      pend_q   <= 1'b0;
      type_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef EDGE_DETECT_TIMESTAMP_EN
      ts_q     <= '0;
`endif
    end else begin
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      rise_e_q <= rise_e_d;
      fall_e_q <= fall_e_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      type_q   <= type_d;
      ovf_q    <= ovf_d;
`ifdef EDGE_DETECT_TIMESTAMP_EN
      ts_q     <= ts_d;
`endif
    end
  end

  assign rise     = rise_q;
  assign fall     = fall_q;
  assign pending  = pend_q;
  assign ev_type  = type_q;
  assign overflow = ovf_q;
`ifdef EDGE_DETECT_TIMESTAMP_EN
  assign ts       = ts_q;
`endif

endmodule

// File: rtl/edge_detect_multi.sv
// NCH-channel hit edge detector with lowest-index-first event hand-off over valid/ready.
// One event per two cycles; outputs held while valid and not ready. EDGE_DETECT_TIMESTAMP_EN adds oEventTs capture.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 4,
  parameter int TS_W        = 16,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [NCH-1:0]       iHit,
  input  logic                 iEnable,
  input  logic [2*NCH-1:0]     iMode,
  input  logic [HOLDOFF_W-1:0] iHoldoff,
  output logic [NCH-1:0]       oRise,
  output logic [NCH-1:0]       oFall,
  output logic                 oEventValid,
  input  logic                 iEventReady,
  output logic [CH_W-1:0]      oEventCh,
  output logic                 oEventType,
  output logic [NCH-1:0]       oOverflow,
  input  logic                 iClrOverflow,
  output logic [TS_W-1:0]      oEventTs
);

  logic [NCH-1:0] pend, ev_type_v, ack;
  arb_state_e     state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d, sel_ch;
  logic           type_q, type_d, sel_type, handshake;
`ifdef EDGE_DETECT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_ch [NCH];
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d, ev_ts_q, ev_ts_d, sel_ts;
`endif

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_chan
      edge_detect_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .HOLDOFF_W   (HOLDOFF_W)
`ifdef EDGE_DETECT_TIMESTAMP_EN
        , .TS_W      (TS_W)
`endif
      ) u_chan (
        .clk          (iClk),
        .rst_n        (iRst_n),
        .hit          (iHit[c]),
        .enable       (iEnable),
        .mode         (iMode[2*c +: 2]),
        .holdoff      (iHoldoff),
        .ack          (ack[c]),
        .clr_overflow (iClrOverflow),
`ifdef EDGE_DETECT_TIMESTAMP_EN
        .ts_now       (ts_cnt_q),
        .ts           (ts_ch[c]),
`endif
        .rise         (oRise[c]),
        .fall         (oFall[c]),
        .pending      (pend[c]),
        .ev_type      (ev_type_v[c]),
        .overflow     (oOverflow[c])
      );
    end
  endgenerate

  // Scan from the top down so the lowest pending index wins.
  always_comb begin
    sel_ch   = '0;
    sel_type = 1'b0;
`ifdef EDGE_DETECT_TIMESTAMP_EN
    sel_ts   = '0;
`endif
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pend[c]) begin
        sel_ch   = CH_W'(c);
        sel_type = ev_type_v[c];
`ifdef EDGE_DETECT_TIMESTAMP_EN
        sel_ts   = ts_ch[c];
`endif
      end
    end
  end

  assign handshake = (state_q == ARB_PRESENT) && iEventReady;

  always_comb begin
    ack = '0;
    for (int c = 0; c < NCH; c++) ack[c] = handshake && (ch_q == CH_W'(c));
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    type_d  = type_q;
`ifdef EDGE_DETECT_TIMESTAMP_EN
    ev_ts_d  = ev_ts_q;
    ts_cnt_d = ts_cnt_q + TS_W'(1);
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|pend) begin
          state_d = ARB_PRESENT;
          ch_d    = sel_ch;
          type_d  = sel_type;
`ifdef EDGE_DETECT_TIMESTAMP_EN
          ev_ts_d = sel_ts;
`endif
        end
      end
      ARB_PRESENT: if (iEventReady) state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ARB_IDLE;
      ch_q     <= '0;
      type_q   <= 1'b0;
`ifdef EDGE_DETECT_TIMESTAMP_EN
      ev_ts_q  <= '0;
      ts_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      type_q   <= type_d;
`ifdef EDGE_DETECT_TIMESTAMP_EN
      ev_ts_q  <= ev_ts_d;
      ts_cnt_q <= ts_cnt_d;
`endif
    end
  end

  assign oEventValid = (state_q == ARB_PRESENT);
  assign oEventCh    = ch_q;
  assign oEventType  = type_q;
`ifdef EDGE_DETECT_TIMESTAMP_EN
  assign oEventTs    = ev_ts_q;
`else
  assign oEventTs    = '0;
`endif

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-channel rise/fall detector on the TDC hit path.
- Per channel: synchronises an asynchronous hit line, detects edges, qualifies them by a per-channel mode and applies a programmable hold-off (dead time).
- Qualified events are queued as pending flags.
- A priority arbiter hands events one at a time over a valid/ready interface to the downstream timestamp/readout logic.

Parameters:
- NCH, 4, number of hit channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=1).
- HOLDOFF_W, 4, width of the hold-off counter.
- TS_W, 16, coarse timestamp width (used only with the optional feature).

Ports:
- iClk  in  1  system clock.
- iRst_n  in  1  asynchronous active-low reset.
- iHit  in  NCH  asynchronous hit inputs.
- iEnable  in  1  global detection enable.
- iMode  in  2*NCH  per-channel mode, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both.
- iHoldoff  in  HOLDOFF_W  dead-time cycles after an accepted event (0 = none).
- oRise  out  NCH  raw rising-edge pulses, 1 cycle wide.
- oFall  out  NCH  raw falling-edge pulses, 1 cycle wide.
- oEventValid  out  1  an event is presented.
- iEventReady  in  1  consumer accepts the event.
- oEventCh  out  max(1,$clog2(NCH))  channel index of the presented event.
- oEventType  out  1  1 = rise, 0 = fall.
- oOverflow  out  NCH  sticky: an event was lost on this channel.
- iClrOverflow  in  1  clears all oOverflow bits.
- oEventTs  out  TS_W  coarse timestamp of the presented event.

Behaviour:
- Reset: all outputs and internal state are cleared asynchronously on iRst_n low (mid-operation too), including sync chains, history, counters, pending flags and arbiter lock. First evaluation happens on the first iClk after deassertion; no edge is reported from reset state unless a synchronised hit is 1.
- Sync chain: SYNC_STAGES flops, then a one-flop history register. Edge = synced value differs from history.
- oRise/oFall:
  - Registered, gated only by iEnable; mode is ignored.
  - A level change sampled at clock edge k produces a 1-cycle pulse visible after edge k+SYNC_STAGES+1.
- Qualification: an edge is qualified if iEnable=1 and the mode bit for its polarity is set.
- Hold-off:
  - An accepted qualified edge loads the channel counter with iHoldoff.
  - While the counter is nonzero, qualified edges are dropped silently (no overflow) and the counter decrements each cycle regardless of iEnable.
- Pending:
  - An accepted event sets pending[c] and stores its type.
  - If pending[c] is already 1: the stored event is kept, the new one is discarded, and oOverflow[c] is set.
- Arbiter states:
  - IDLE -> PRESENT when any pending bit is set. Selects the lowest-index pending channel and registers oEventValid=1, oEventCh and oEventType.
  - PRESENT holds all outputs stable until oEventValid&iEventReady. On handshake it clears that pending bit and returns to IDLE.
  - Throughput is one event per 2 cycles. iEventReady is ignored while oEventValid=0.
- Simultaneous events:
  - Handshake on channel c in the same cycle a new event is accepted on c: pending stays set with the new type, and no overflow is flagged.
  - iClrOverflow in the same cycle as a new overflow: set wins.
- iEnable=0:
  - Sync chains and history keep running, so re-enabling produces no spurious edge.
  - Already-pending events are still delivered.

Optional Feature:
- Macro EDGE_DETECT_TIMESTAMP_EN.
- Defined:
  - A free-running TS_W-bit counter (reset 0, wraps) runs continuously.
  - Its value is captured per channel when an event is accepted (overwrite case: the value is not updated).
  - The captured value is presented on oEventTs with the event and held stable with it.
- Undefined: oEventTs is tied to 0 and no counter or capture registers exist.

Decomposition:
- Package edge_detect_pkg: mode localparams (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH), event-type constants, arbiter state enum.
- Sub-module edge_detect_chan, instantiated NCH times: sync chain, history, raw pulses, qualification, hold-off counter, pending/type/overflow bits, optional timestamp capture.
- The top level contains the arbiter and the free-running counter.

Test Plan:
- Latency: SYNC_STAGES=2, mode 01 on ch0, iHit[0] 0->1 -> oRise[0] high for exactly 1 cycle, 3 edges after the sampling edge. oEventValid=1 next cycle, oEventCh=0, oEventType=1.
- Mode: mode 10 on ch1, pulse iHit[1] high for 5 cycles -> oRise and oFall both pulse; exactly one event, with oEventType=0.
- Hold-off: iHoldoff=4, ch2 mode 11, toggle iHit[2] every 2 cycles -> events only for edges at least 4 cycles apart after each accept; oOverflow[2] stays 0.
- Arbitration/backpressure: iEventReady=0, simultaneous rises on ch3 and ch1 -> ch1 presented and held stable. A second ch1 edge sets oOverflow[1]. Raising iEventReady delivers ch1, then ch3.
- Reset: assert iRst_n low while oEventValid=1 -> oEventValid, oOverflow and pending clear immediately; no event after release with iHit static low.
- With EDGE_DETECT_TIMESTAMP_EN: event accepted when the counter reads 0x00FF -> oEventTs=0x00FF. Counter wrap from 0xFFFF to 0x0000 is verified.
